// File: rtl/plug_board_map_if.sv
// Stream and configuration bundle for the plugboard substitution stage.
// The slave modport is the plugboard's view; master is the driver/observer side.
interface plug_board_map_if #(
    parameter int LETTER_W = 5
);
    logic                  pair_vld;
    logic [2*LETTER_W-1:0] pair;
    logic                  clr;
    logic                  start;
    logic                  in_vld;
    logic                  in_rdy;
    logic [LETTER_W-1:0]   in_let;
    logic                  out_vld;
    logic                  out_rdy;
    logic [LETTER_W-1:0]   out_let;
    logic [3:0]            pair_cnt;
    logic                  err;
    logic                  running;

    modport slave (
        input  pair_vld, pair, clr, start, in_vld, in_let, out_rdy,
        output in_rdy, out_vld, out_let, pair_cnt, err, running
    );

    modport master (
        output pair_vld, pair, clr, start, in_vld, in_let, out_rdy,
        input  in_rdy, out_vld, out_let, pair_cnt, err, running
    );
endinterface

// File: rtl/plug_board_map.sv
// Plugboard stage: collects validated swap pairs in CONFIG, then substitutes
// letters on a one-register valid/ready pipeline in RUN.
module plug_board_map #(
    parameter int NUM_PAIRS = 10,
    parameter int LETTER_W  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    plug_board_map_if.slave    bus
);
    localparam int MW = 1 << LETTER_W;
    localparam logic [LETTER_W-1:0] LAST_LET = LETTER_W'(25);

    typedef enum logic {S_CONFIG, S_RUN} state_t;

    state_t                             r_state;
    logic [NUM_PAIRS-1:0][LETTER_W-1:0] r_tab_a;
    logic [NUM_PAIRS-1:0][LETTER_W-1:0] r_tab_b;
    logic [25:0]                        r_mask;
    logic [3:0]                         r_cnt;
    logic                               r_err;
    logic                               r_out_vld;
    logic [LETTER_W-1:0]                r_out_let;

    logic [LETTER_W-1:0] w_a;
    logic [LETTER_W-1:0] w_b;
    logic [MW-1:0]       w_used;
    logic [MW-1:0]       w_set;
    logic                w_ok;
    logic                w_run;
    logic                w_in_rdy;
    logic                w_xfer;
    logic [LETTER_W-1:0] w_sub;

    assign w_a    = bus.pair[LETTER_W-1:0];
    assign w_b    = bus.pair[2*LETTER_W-1:LETTER_W];
    assign w_used = MW'(r_mask);
    assign w_set  = (MW'(1) << w_a) | (MW'(1) << w_b);

    // Range is checked first so the mask lookup never sees an unplugged high code.
    assign w_ok = (w_a <= LAST_LET) && (w_b <= LAST_LET) && (w_a != w_b) &&
                  !w_used[w_a] && !w_used[w_b] && (r_cnt < 4'(NUM_PAIRS));

    assign w_run    = (r_state == S_RUN);
    assign w_in_rdy = w_run && (!r_out_vld || bus.out_rdy);
    assign w_xfer   = bus.in_vld && w_in_rdy;

    // Pairs are disjoint, so at most one live entry can match.
    always_comb begin
        w_sub = bus.in_let;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (4'(i) < r_cnt) begin
                if (bus.in_let == r_tab_a[i])      w_sub = r_tab_b[i];
                else if (bus.in_let == r_tab_b[i]) w_sub = r_tab_a[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.clr) begin
            r_state   <= S_CONFIG;
            r_tab_a   <= '0;
            r_tab_b   <= '0;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_let <= '0;
        end else begin
            r_err <= bus.pair_vld && (w_run || !w_ok);
            if (!w_run) begin
                if (bus.pair_vld && w_ok) begin
                    r_tab_a[r_cnt] <= w_a;
                    r_tab_b[r_cnt] <= w_b;
                    r_mask         <= r_mask | w_set[25:0];
                    r_cnt          <= r_cnt + 4'd1;
                end
                if (bus.start) r_state <= S_RUN;
            end else begin
                if (w_xfer) begin
                    r_out_vld <= 1'b1;
                    r_out_let <= w_sub;
                end else if (bus.out_rdy) begin
                    r_out_vld <= 1'b0;
                end
            end
        end
    end

    assign bus.in_rdy   = w_in_rdy;
    assign bus.out_vld  = r_out_vld;
    assign bus.out_let  = r_out_let;
    assign bus.pair_cnt = r_cnt;
    assign bus.err      = r_err;
    assign bus.running  = w_run;
endmodule
